io_uart_drain: RTL and testbench
================================

Name: io_uart_drain

Overview:
Sits directly downstream of the Hubris core's external IO port. It drains the core's output byte buffer, using the io_buffer_size_avai / io_output_en / io_output_data handshake, and serialises each byte onto an 8N1-style UART TX line. This lets program output, for example from printf-style stores to the IO region, leave the chip without a testbench reading the buffer directly.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (868 = 100 MHz / 115200); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock, all state updated on rising edge
reset  in  1  asynchronous, active-low reset
tx_enable  in  1  1 = allowed to start popping new bytes; 0 = finish current frame, then hold idle
io_buffer_size_avai  in  32  bytes currently held in the core's IO buffer
io_output_data  in  8  head byte of the core's IO buffer; valid whenever io_buffer_size_avai != 0
io_output_en  out  1  pop strobe to core; one-cycle pulse removes the head byte at that rising edge
uart_tx  out  1  serial line, idle high
busy  out  1  1 while in any state other than IDLE
drained  out  1  1 when in IDLE and io_buffer_size_avai == 0
bytes_sent  out  32  count of completed frames, wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE, uart_tx = 1, io_output_en = 0, busy = 0, bytes_sent = 0.
  - Bit and baud counters = 0, shift register = 0.
  - drained reflects io_buffer_size_avai == 0 combinationally.
- All outputs except drained are registered.
- IDLE:
  - uart_tx = 1.
  - If tx_enable && io_buffer_size_avai != 0, go to POP next cycle; otherwise stay in IDLE.
- POP (exactly 1 cycle):
  - io_output_en = 1 and uart_tx = 1.
  - io_output_data is captured into the shift register at the end of this cycle; the core decrements its count on the same edge.
  - Next state: START.
- START: uart_tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter 0..7; after bit 7, go to PARITY (if enabled) or STOP.
- STOP:
  - uart_tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle, bytes_sent increments by 1 and the next state is IDLE.
- io_output_en is never high outside POP, and never high for 2 consecutive cycles.
- Frame length in cycles: (1 + 8 + STOP_BITS) * CLKS_PER_BIT, plus CLKS_PER_BIT if parity is enabled.
- Back-to-back gap:
  - Minimum 2 extra high cycles between frames (1 in IDLE, 1 in POP).
  - The START falling edge of frame N+1 occurs exactly frame_len + 2 cycles after the START falling edge of frame N.
- tx_enable:
  - Deasserting mid-frame does not abort; the frame completes and the block then waits in IDLE.
  - Sampled only in IDLE.
- Buffer count:
  - io_buffer_size_avai changing mid-frame has no effect.
  - It is evaluated only in IDLE, which is always at least 1 cycle after POP, so the post-pop count is already visible.
- Reset mid-frame:
  - uart_tx returns high immediately.
  - The byte already popped is lost; this is accepted behaviour.
  - No pop is issued until reset is released and IDLE conditions hold.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT).
  - Reloads to 0 on every bit boundary and on entry to START.

Optional Feature:
IO_UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (10 + STOP_BITS) * CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes straight to STOP; frame is 8N1/8N2.

Test Plan:
- Single byte, no parity:
  - Setup: CLKS_PER_BIT=4, STOP_BITS=1, tx_enable=1, size 0->1, data 0x55.
  - Expect: exactly one io_output_en pulse.
  - Expect: uart_tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total), then high; bytes_sent = 1, drained = 1.
- Back-to-back bytes:
  - Setup: size=3, bytes 0x41, 0x42, 0x43.
  - Expect: 3 io_output_en pulses; consecutive START falling edges exactly 42 cycles apart.
  - Expect: decoded bytes 0x41, 0x42, 0x43; bytes_sent = 3.
- Enable gating:
  - Setup: tx_enable=0, size=5, hold 100 cycles.
  - Expect: io_output_en never 1, uart_tx = 1, busy = 0, drained = 0.
  - Then tx_enable=1: first pop occurs within 2 cycles.
- Disable mid-frame:
  - Setup: tx_enable drops during DATA bit 3, size still 2.
  - Expect: current frame completes, no further pop, bytes_sent increments by 1 only.
- Reset mid-frame:
  - Setup: assert reset in DATA bit 5, asynchronously.
  - Expect: uart_tx = 1 within the same cycle, bytes_sent = 0, busy = 0.
  - After release with size=1: a new full frame is sent.
- Parity (IO_UART_PARITY_EN defined):
  - Data 0x07: parity bit = 1, frame = 44 cycles at CLKS_PER_BIT=4.
  - Data 0x03: parity bit = 0.

Source files
------------

// File: rtl/io_uart_drain.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_drain
// Description : Drains the core's IO output byte buffer through the
//               io_buffer_size_avai / io_output_en / io_output_data handshake
//               and serialises each byte onto an 8N1 (or 8N2) UART TX line.
//               One byte is popped per frame. The head byte is captured in the
//               same cycle as the pop strobe.
// Optional    : `define IO_UART_PARITY_EN adds an even-parity bit between the
//               data bits and the stop bit(s).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT        clock cycles per UART bit, 2..65535
//   STOP_BITS           number of stop bits, 1 or 2
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous reset, active low
//   tx_enable           in   permit popping new bytes (sampled in IDLE only)
//   io_buffer_size_avai in   bytes currently held in the core's IO buffer
//   io_output_data      in   head byte of the core's IO buffer
//   io_output_en        out  one-cycle pop strobe to the core
//   uart_tx             out  serial line, idle high
//   busy                out  high in any state other than IDLE
//   drained             out  IDLE and buffer empty (combinational)
//   bytes_sent          out  completed frame count, wraps
// ============================================================================
module io_uart_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic [31:0] io_buffer_size_avai,
  input  logic [7:0]  io_output_data,
  output logic        io_output_en,
  output logic        uart_tx,
  output logic        busy,
  output logic        drained,
  output logic [31:0] bytes_sent
);

  localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]        shift_reg;
`ifdef IO_UART_PARITY_EN
  logic              parity_bit;
`endif

  logic baud_end;
  logic start_ok;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign start_ok = tx_enable && (io_buffer_size_avai != 32'd0);

  // The buffer count is only meaningful while idle; mid-frame it is ignored.
  assign drained  = (state == IDLE) && (io_buffer_size_avai == 32'd0);

  // uart_tx is registered: every transition loads the level the next state
  // drives, so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      uart_tx      <= 1'b1;
      io_output_en <= 1'b0;
      busy         <= 1'b0;
      bytes_sent   <= 32'd0;
      baud_cnt     <= '0;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'd0;
`ifdef IO_UART_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          uart_tx      <= 1'b1;
          io_output_en <= 1'b0;
          if (start_ok) begin
            state        <= POP;
            io_output_en <= 1'b1;
            busy         <= 1'b1;
          end
        end

        // Single cycle: strobe is high, head byte is captured at its end and
        // the core drops the byte on the same edge.
        POP: begin
          io_output_en <= 1'b0;
          shift_reg    <= io_output_data;
`ifdef IO_UART_PARITY_EN
          parity_bit   <= ^io_output_data;
`endif
          state        <= START;
          uart_tx      <= 1'b0;
          baud_cnt     <= '0;
          bit_cnt      <= 3'd0;
        end

        START: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            state     <= DATA;
            uart_tx   <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
`ifdef IO_UART_PARITY_EN
              state   <= PARITY;
              uart_tx <= parity_bit;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              uart_tx   <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

`ifdef IO_UART_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            state    <= STOP;
            uart_tx  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`endif

        // bit_cnt counts stop bits so STOP_BITS=2 simply repeats the period.
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt    <= 3'd0;
              state      <= IDLE;
              busy       <= 1'b0;
              bytes_sent <= bytes_sent + 32'd1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          state        <= IDLE;
          uart_tx      <= 1'b1;
          io_output_en <= 1'b0;
          busy         <= 1'b0;
          baud_cnt     <= '0;
          bit_cnt      <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_uart_drain
// Description : Self-checking bench for io_uart_drain at CLKS_PER_BIT=4,
//               STOP_BITS=1. A queue models the core's IO buffer; a serial
//               monitor decodes every frame and checks each bit is steady for
//               its whole period. Honours `define IO_UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_drain;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef IO_UART_PARITY_EN
  localparam int NBITS = 11;  // start + 8 data + parity + stop
  localparam int GAP   = 46;  // 44-cycle frame + IDLE + POP
`else
  localparam int NBITS = 10;
  localparam int GAP   = 42;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic [31:0] io_buffer_size_avai = 32'd0;
  logic [7:0]  io_output_data = 8'd0;
  logic        io_output_en;
  logic        uart_tx;
  logic        busy;
  logic        drained;
  logic [31:0] bytes_sent;

  io_uart_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk                 (clk),
    .reset               (reset),
    .tx_enable           (tx_enable),
    .io_buffer_size_avai (io_buffer_size_avai),
    .io_output_data      (io_output_data),
    .io_output_en        (io_output_en),
    .uart_tx             (uart_tx),
    .busy                (busy),
    .drained             (drained),
    .bytes_sent          (bytes_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core IO buffer model ----------------
  logic [7:0] fifo[$];

  task automatic refresh();
    io_buffer_size_avai = 32'(fifo.size());
    io_output_data      = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic flush();
    fifo.delete();
    refresh();
  endtask

  int   pops = 0;
  int   en_double = 0;
  logic prev_en = 1'b0;

  // The pop takes effect at the edge ending the strobe cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (io_output_en === 1'b1) begin
        pops++;
        if (prev_en) en_double++;
        prev_en = 1'b1;
        @(posedge clk);
        #1;
        if (fifo.size() != 0) fifo.delete(0);
        refresh();
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  // ---------------- serial monitor ----------------
  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       framing_ok;
    logic       steady;
    int         t0;
  } frame_t;

  frame_t rx[$];

  initial begin
    logic        prev_tx;
    logic [15:0] bv;
    logic        steady;
    logic        aborted;
    int          t0;
    frame_t      fr;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && prev_tx && (uart_tx === 1'b0)) begin
        t0 = cyc; steady = 1'b1; aborted = 1'b0; bv = '0;
        for (int k = 0; k < NBITS * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) bv[k / CPB] = uart_tx;
          else if (bv[k / CPB] !== uart_tx) steady = 1'b0;
        end
        if (!aborted) begin
          fr.d = bv[8:1];
`ifdef IO_UART_PARITY_EN
          fr.p = bv[9];
`else
          fr.p = 1'b0;
`endif
          fr.framing_ok = (bv[0] == 1'b0) && (bv[NBITS-1] == 1'b1);
          fr.steady     = steady;
          fr.t0         = t0;
          rx.push_back(fr);
        end
      end
      prev_tx = uart_tx;
    end
  end

  // Wait for n decoded frames in total and the block back in IDLE.
  task automatic wait_idle(input int n, input string name);
    int t;
    t = 0;
    while ((rx.size() < n || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, 32'(t < 2000), 32'd1);
  endtask

  task automatic wait_pop(input int limit, output int t);
    t = 0;
    while (io_output_en !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed single-byte table ----------------
  typedef struct {
    logic [7:0]  data;
    logic        par;   // even parity of data
    logic [31:0] sent;  // bytes_sent after this frame
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_rx;
    int base_pops;
    int t;
    int bad_en, bad_tx, bad_busy, bad_drained;

    vecs[0] = '{8'h55, 1'b0, 32'd1};
    vecs[1] = '{8'h00, 1'b0, 32'd2};
    vecs[2] = '{8'hFF, 1'b0, 32'd3};
    vecs[3] = '{8'h07, 1'b1, 32'd4};
    vecs[4] = '{8'h03, 1'b0, 32'd5};
    vecs[5] = '{8'h80, 1'b1, 32'd6};

    refresh();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",      32'(uart_tx), 32'd1);
    check("rst_en",      32'(io_output_en), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_sent",    bytes_sent, 32'd0);
    check("rst_drained", 32'(drained), 32'd1);
    reset = 1'b1;
    tx_enable = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base_rx = rx.size();
      base_pops = pops;
      push_byte(vecs[i].data);
      wait_idle(base_rx + 1, "vec");
      if (rx.size() > base_rx) begin
        check("vec_data",    32'(rx[base_rx].d), 32'(vecs[i].data));
`ifdef IO_UART_PARITY_EN
        check("vec_parity",  32'(rx[base_rx].p), 32'(vecs[i].par));
`endif
        check("vec_framing", 32'(rx[base_rx].framing_ok), 32'd1);
        check("vec_steady",  32'(rx[base_rx].steady), 32'd1);
      end
      check("vec_pops",    32'(pops - base_pops), 32'd1);
      check("vec_sent",    bytes_sent, vecs[i].sent);
      check("vec_drained", 32'(drained), 32'd1);
      check("vec_idle_tx", 32'(uart_tx), 32'd1);
    end

    // ---------------- back-to-back ----------------
    base_rx = rx.size();
    base_pops = pops;
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    wait_idle(base_rx + 3, "b2b");
    if (rx.size() >= base_rx + 3) begin
      check("b2b_d0",   32'(rx[base_rx].d),     32'h41);
      check("b2b_d1",   32'(rx[base_rx + 1].d), 32'h42);
      check("b2b_d2",   32'(rx[base_rx + 2].d), 32'h43);
      check("b2b_gap0", 32'(rx[base_rx + 1].t0 - rx[base_rx].t0), 32'(GAP));
      check("b2b_gap1", 32'(rx[base_rx + 2].t0 - rx[base_rx + 1].t0), 32'(GAP));
    end
    check("b2b_pops", 32'(pops - base_pops), 32'd3);
    check("b2b_sent", bytes_sent, 32'd9);
    check("en_never_double", 32'(en_double), 32'd0);

    // ---------------- enable gating ----------------
    tx_enable = 1'b0;
    base_pops = pops;
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    bad_en = 0; bad_tx = 0; bad_busy = 0; bad_drained = 0;
    repeat (100) begin
      @(negedge clk);
      if (io_output_en !== 1'b0) bad_en++;
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (drained !== 1'b0) bad_drained++;
    end
    check("gate_en",      32'(bad_en), 32'd0);
    check("gate_tx",      32'(bad_tx), 32'd0);
    check("gate_busy",    32'(bad_busy), 32'd0);
    check("gate_drained", 32'(bad_drained), 32'd0);

    tx_enable = 1'b1;
    base_rx = rx.size();
    @(negedge clk);
    wait_pop(3, t);
    check("gate_pop_latency", 32'(t <= 1), 32'd1);

    // ---------------- disable during data bit 3 ----------------
    repeat (18) @(negedge clk);
    check("dis_in_frame", 32'(busy), 32'd1);
    tx_enable = 1'b0;
    wait_idle(base_rx + 1, "dis");
    repeat (60) @(negedge clk);
    check("dis_pops", 32'(pops - base_pops), 32'd1);
    check("dis_sent", bytes_sent, 32'd10);
    check("dis_left", io_buffer_size_avai, 32'd4);
    check("dis_busy", 32'(busy), 32'd0);
    if (rx.size() > base_rx) check("dis_data", 32'(rx[base_rx].d), 32'h60);
    flush();

    // ---------------- reset during data bit 5 ----------------
    base_rx = rx.size();
    tx_enable = 1'b1;
    push_byte(8'hC3);  // bit 5 is 0, so the line is low when reset hits
    wait_pop(20, t);
    check("rst_mid_pop_seen", 32'(io_output_en), 32'd1);
    repeat (26) @(negedge clk);
    check("rst_mid_line_low", 32'(uart_tx), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_tx",   32'(uart_tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sent", bytes_sent, 32'd0);
    check("rst_mid_en",   32'(io_output_en), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    base_pops = pops;
    push_byte(8'hA5);
    wait_idle(base_rx + 1, "rst_after");
    if (rx.size() > base_rx) begin
      check("rst_after_data",   32'(rx[base_rx].d), 32'hA5);
      check("rst_after_steady", 32'(rx[base_rx].steady), 32'd1);
    end
    check("rst_after_pops",    32'(pops - base_pops), 32'd1);
    check("rst_after_sent",    bytes_sent, 32'd1);
    check("rst_after_drained", 32'(drained), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
